keypad_entry_shaper: RTL and testbench
======================================

// Module: keypad_entry_shaper
// PURPOSE
//  Upstream front end of the access-control FSM. Debounces raw board push-buttons
//  and assembles 4-bit digit entries into one 16-bit word. Presents that word on
//  Data_Out with a single-cycle Data_Load strobe. Data_Out and Data_Load drive the
//  FSM's _Data_In and _Data_In_Load inputs directly. Data_Out holds steady after
//  the strobe so the FSM can sample it in any later cycle.
// PARAMETERS
//  DB_CYCLES  default 8  consecutive stable cycles required to accept a button level change
//  DB_WIDTH   default 4  width of each debounce counter; must satisfy 2**DB_WIDTH > DB_CYCLES
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst          in   1   synchronous reset, active-low
//  Digit_In     in   4   digit value from switches, sampled when a digit press is accepted
//  Digit_Btn    in   1   raw asynchronous button, active-high: append Digit_In
//  Enter_Btn    in   1   raw asynchronous button, active-high: commit the entry
//  Clear_Btn    in   1   raw asynchronous button, active-high: discard the entry
//  Data_Out     out  16  committed word; held until the next commit
//  Data_Load    out  1   one-cycle strobe, high in the cycle Data_Out takes a new value
//  Digit_Count  out  3   digits currently buffered, 0..4
//  Entry_Full   out  1   high when Digit_Count == 4
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - Data_Out=0, Data_Load=0, Digit_Count=0, Entry_Full=0.
//   - Shift register=0, all sync flops=0, debounced levels=0, debounce counters=0, FSM=EMPTY.
//  Input path, per button:
//   - 2-flop synchronizer feeds the debouncer.
//   - Counter increments while the synced level != debounced level; it clears when they match.
//   - When the counter reaches DB_CYCLES, the debounced level flips and the counter clears.
//   - A press event is a registered 0->1 edge of the debounced level; it lasts 1 cycle.
//   - Releases generate no event.
//   - Glitches shorter than DB_CYCLES cycles produce no event.
//  Latency:
//   - A raw level first sampled high at posedge N and held produces its press event in
//     cycle N+DB_CYCLES+3.
//   - An Enter event yields Data_Load in cycle N+DB_CYCLES+4, i.e. 1 cycle after the event.
//  FSM states: EMPTY, COLLECT, FULL, COMMIT.
//   - EMPTY, digit event: shift <= {shift[11:0],Digit_In}, count++, go to COLLECT.
//   - COLLECT, digit event: shift and count++; go to FULL when count becomes 4.
//   - FULL, digit event: ignored, no shift, count stays 4.
//   - COLLECT or FULL, enter event: Data_Out <= shift, Data_Load <= 1, go to COMMIT.
//     A partial entry commits right-aligned with upper nibbles zero,
//     e.g. digits 1,2 -> 16'h0012.
//   - EMPTY, enter event: ignored, no strobe.
//   - COMMIT (1 cycle): Data_Load <= 0, shift <= 0, count <= 0, go to EMPTY.
//     Events arriving in COMMIT are dropped.
//   - Clear event, any state except COMMIT: shift <= 0, count <= 0, go to EMPTY.
//     Data_Out is unchanged and there is no strobe.
//  Simultaneous events in the same cycle: priority Clear > Enter > Digit.
//   Only the winning event acts; the losers are discarded.
//  Entry_Full is a registered copy of (count==4), consistent with Digit_Count in the same cycle.
//  Mid-operation reset:
//   - Takes effect at the next posedge regardless of state; a pending strobe is cancelled.
//   - A button held through reset release is seen as a new press once it has been
//     stable DB_CYCLES cycles after release.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles with all buttons high.
//    -> All outputs 0 during reset.
//    -> After release, one Digit event is accepted, Digit_Count=1.
//  2 Debounce: Digit_Btn pulse lasting DB_CYCLES-1 cycles, plus 1-cycle chatter.
//    -> Digit_Count stays 0.
//    -> A clean press held DB_CYCLES+4 cycles gives Digit_Count=1 at the exact latency.
//  3 Full entry: digits A,B,C,D then Enter.
//    -> Data_Out=16'hABCD, Data_Load high exactly 1 cycle at N+DB_CYCLES+4.
//    -> Digit_Count returns to 0; Data_Out holds 16'hABCD for 100 cycles.
//  4 Overflow: digits 1,2,3,4,5 then Enter.
//    -> Entry_Full=1 after the 4th digit; the 5th is ignored; Data_Out=16'h1234.
//  5 Partial entry and Clear:
//    -> Digits 7,8 then Enter gives 16'h0078.
//    -> Digits 9 then Clear then Enter gives no strobe and Data_Out stays 16'h0078.
//  6 Priority: Clear and Enter debounced in the same cycle after digits 1,2.
//    -> No Data_Load, Digit_Count=0.
//    -> Enter and Digit together: commit occurs and the digit is dropped.

Source files
------------

// File: rtl/keypad_entry_shaper_if.sv
// Keypad front-end bundle: raw buttons and digit switches in,
// committed word, load strobe and entry status out.
interface keypad_entry_shaper_if;
    logic [3:0]  Digit_In;
    logic        Digit_Btn;
    logic        Enter_Btn;
    logic        Clear_Btn;
    logic [15:0] Data_Out;
    logic        Data_Load;
    logic [2:0]  Digit_Count;
    logic        Entry_Full;

    modport master (
        output Digit_In, Digit_Btn, Enter_Btn, Clear_Btn,
        input  Data_Out, Data_Load, Digit_Count, Entry_Full
    );

    modport slave (
        input  Digit_In, Digit_Btn, Enter_Btn, Clear_Btn,
        output Data_Out, Data_Load, Digit_Count, Entry_Full
    );
endinterface

// File: rtl/keypad_entry_shaper.sv
// Debounces the keypad buttons and assembles up to four nibbles
// into a 16-bit word committed with a one-cycle load strobe.
module keypad_entry_shaper #(
    parameter int DB_CYCLES = 8,
    parameter int DB_WIDTH  = 4
) (
    input logic clk,
    input logic rst,
    keypad_entry_shaper_if.slave bus
);
    localparam logic [DB_WIDTH-1:0] DbMax = DB_WIDTH'(DB_CYCLES);

    typedef enum logic [1:0] {
        EMPTY,
        COLLECT,
        FULL,
        COMMIT
    } state_t;

    // Bit order in all button vectors: {clear, enter, digit}
    logic [2:0] raw;
    logic [2:0] s1_q;
    logic [2:0] s2_q;
    logic [2:0] lvl_q;
    logic [2:0] lvl_d;
    logic [2:0] prev_q;
    logic [2:0] evt_q;
    logic [2:0][DB_WIDTH-1:0] cnt_q;
    logic [2:0][DB_WIDTH-1:0] cnt_d;

    state_t      state_q;
    logic [15:0] shift_q;
    logic [15:0] data_q;
    logic        load_q;
    logic [2:0]  count_q;
    logic        full_q;

    assign raw = {bus.Clear_Btn, bus.Enter_Btn, bus.Digit_Btn};

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (s2_q[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DbMax) begin
                cnt_d[i] = '0;
                lvl_d[i] = ~lvl_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            lvl_q  <= '0;
            prev_q <= '0;
            evt_q  <= '0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            prev_q <= lvl_q;
            evt_q  <= lvl_q & ~prev_q;
            cnt_q  <= cnt_d;
        end
    end

    // Event priority: clear, then enter, then digit; losers are dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            shift_q <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            unique case (state_q)
                COMMIT: begin
                    load_q  <= 1'b0;
                    shift_q <= '0;
                    count_q <= '0;
                    full_q  <= 1'b0;
                    state_q <= EMPTY;
                end
                default: begin
                    if (evt_q[2]) begin
                        shift_q <= '0;
                        count_q <= '0;
                        full_q  <= 1'b0;
                        state_q <= EMPTY;
                    end else if (evt_q[1]) begin
                        if (state_q != EMPTY) begin
                            data_q  <= shift_q;
                            load_q  <= 1'b1;
                            state_q <= COMMIT;
                        end
                    end else if (evt_q[0]) begin
                        if (state_q != FULL) begin
                            shift_q <= {shift_q[11:0], bus.Digit_In};
                            count_q <= count_q + 3'd1;
                            full_q  <= (count_q == 3'd3);
                            state_q <= (count_q == 3'd3) ? FULL : COLLECT;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.Data_Out    = data_q;
    assign bus.Data_Load   = load_q;
    assign bus.Digit_Count = count_q;
    assign bus.Entry_Full  = full_q;
endmodule

// File: tb/tb_keypad_entry_shaper.sv
// Directed and random keypad presses checked against an
// entry-buffer model of digits, commits and clears.
module tb_keypad_entry_shaper;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    int loads = 0;
    int exp_loads = 0;
    logic [3:0]  q[$];
    logic [15:0] m_data = '0;

    keypad_entry_shaper_if bus();

    keypad_entry_shaper #(.DB_CYCLES(DB), .DB_WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.Data_Load === 1'b1) loads++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack_q();
        logic [15:0] v = '0;
        foreach (q[i]) v = (v << 4) | 16'(q[i]);
        return v;
    endfunction

    task automatic model_event(input logic d, input logic e,
                               input logic c, input logic [3:0] v);
        if (c) begin
            q.delete();
        end else if (e) begin
            if (q.size() > 0) begin
                m_data = pack_q();
                exp_loads++;
                q.delete();
            end
        end else if (d) begin
            if (q.size() < 4) q.push_back(v);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(bus.Digit_Count), 32'(q.size()));
        chk({tag, ".full"}, 32'(bus.Entry_Full), 32'(q.size() == 4));
        chk({tag, ".data"}, 32'(bus.Data_Out), 32'(m_data));
        chk({tag, ".loads"}, loads, exp_loads);
    endtask

    task automatic release_all();
        bus.Digit_Btn = 1'b0;
        bus.Enter_Btn = 1'b0;
        bus.Clear_Btn = 1'b0;
        repeat (DB + 6) @(negedge clk);
    endtask

    task automatic do_press(input logic d, input logic e, input logic c,
                            input logic [3:0] v, input string tag);
        @(negedge clk);
        bus.Digit_In  = v;
        bus.Digit_Btn = d;
        bus.Enter_Btn = e;
        bus.Clear_Btn = c;
        repeat (DB + 6) @(negedge clk);
        release_all();
        model_event(d, e, c, v);
        check_state(tag);
    endtask

    initial begin
        bus.Digit_In  = 4'h5;
        bus.Digit_Btn = 1'b1;
        bus.Enter_Btn = 1'b1;
        bus.Clear_Btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.data", 32'(bus.Data_Out), 0);
            chk("rst.load", 32'(bus.Data_Load), 0);
            chk("rst.count", 32'(bus.Digit_Count), 0);
            chk("rst.full", 32'(bus.Entry_Full), 0);
        end
        rst = 1'b1;
        bus.Enter_Btn = 1'b0;
        bus.Clear_Btn = 1'b0;
        repeat (DB + 6) @(negedge clk);
        release_all();
        model_event(1'b1, 1'b0, 1'b0, 4'h5);
        check_state("rst.held");
        do_press(0, 0, 1, 4'h0, "rst.clr");

        // Short pulse and single-cycle chatter must be rejected
        @(negedge clk);
        bus.Digit_In = 4'h3;
        bus.Digit_Btn = 1'b1;
        repeat (DB - 1) @(negedge clk);
        bus.Digit_Btn = 1'b0;
        repeat (3) @(negedge clk);
        bus.Digit_Btn = 1'b1;
        @(negedge clk);
        bus.Digit_Btn = 1'b0;
        repeat (2 * DB) @(negedge clk);
        check_state("glitch");
        bus.Digit_Btn = 1'b1;
        for (int i = 1; i <= DB + 6; i++) begin
            @(negedge clk);
            if (i == DB + 4) chk("lat.before", 32'(bus.Digit_Count), 0);
            if (i == DB + 5) chk("lat.at", 32'(bus.Digit_Count), 1);
        end
        release_all();
        model_event(1'b1, 1'b0, 1'b0, 4'h3);
        check_state("lat");
        do_press(0, 0, 1, 4'h0, "lat.clr");

        do_press(1, 0, 0, 4'hA, "full.a");
        do_press(1, 0, 0, 4'hB, "full.b");
        do_press(1, 0, 0, 4'hC, "full.c");
        do_press(1, 0, 0, 4'hD, "full.d");
        @(negedge clk);
        bus.Enter_Btn = 1'b1;
        for (int i = 1; i <= DB + 7; i++) begin
            @(negedge clk);
            chk("ent.strobe", 32'(bus.Data_Load), 32'(i == DB + 5));
        end
        release_all();
        model_event(1'b0, 1'b1, 1'b0, 4'h0);
        check_state("ent");
        chk("ent.abcd", 32'(bus.Data_Out), 32'h0000ABCD);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 10 == 9) chk("hold", 32'(bus.Data_Out), 32'h0000ABCD);
        end

        for (int i = 1; i <= 5; i++)
            do_press(1, 0, 0, 4'(i), "ovf.dig");
        do_press(0, 1, 0, 4'h0, "ovf.ent");
        chk("ovf.1234", 32'(bus.Data_Out), 32'h00001234);

        do_press(1, 0, 0, 4'h7, "part.7");
        do_press(1, 0, 0, 4'h8, "part.8");
        do_press(0, 1, 0, 4'h0, "part.ent");
        chk("part.0078", 32'(bus.Data_Out), 32'h00000078);
        do_press(1, 0, 0, 4'h9, "clr.9");
        do_press(0, 0, 1, 4'h0, "clr.clr");
        do_press(0, 1, 0, 4'h0, "clr.ent");
        chk("clr.0078", 32'(bus.Data_Out), 32'h00000078);

        do_press(1, 0, 0, 4'h1, "pri.1");
        do_press(1, 0, 0, 4'h2, "pri.2");
        do_press(0, 1, 1, 4'h0, "pri.ce");
        do_press(1, 0, 0, 4'h4, "pri.4");
        do_press(1, 1, 0, 4'h5, "pri.ed");
        chk("pri.0004", 32'(bus.Data_Out), 32'h00000004);

        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0)
                do_press(0, 0, 1, 4'h0, "rnd.clr");
            else if (r <= 2)
                do_press(0, 1, 0, 4'h0, "rnd.ent");
            else if (r == 3)
                do_press(1, 1, 0, 4'($urandom), "rnd.ed");
            else if (r == 4)
                do_press(1, $urandom_range(0, 1), 1, 4'($urandom), "rnd.cx");
            else
                do_press(1, 0, 0, 4'($urandom), "rnd.dig");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
